// File: rtl/goboard_pkg.sv
// Shared types and constants for the Go board row-memory update scheduler.
// Cell codes are 2 bits: bit 2c = black, bit 2c+1 = white.
package goboard_pkg;

    localparam int ROWS  = 19;
    localparam int ROW_W = 2 * ROWS;

    localparam logic [4:0] LAST_ROW = 5'(ROWS - 1);

    localparam logic [1:0] CELL_EMPTY = 2'b00;
    localparam logic [1:0] CELL_BLACK = 2'b01;
    localparam logic [1:0] CELL_WHITE = 2'b10;
    localparam logic [1:0] CELL_RSVD  = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StModify,
        StWrite,
        StReject,
        StClear
    } sched_state_e;

    function automatic logic [ROW_W-1:0] set_cell(input logic [ROW_W-1:0] row,
                                                  input logic [4:0]       col,
                                                  input logic [1:0]       code);
        logic [ROW_W-1:0] mask;
        mask = ROW_W'(2'b11) << {col, 1'b0};
        return (row & ~mask) | (ROW_W'(code) << {col, 1'b0});
    endfunction

endpackage

// File: rtl/goboard_rr_arb.sv
// Two-way round-robin arbiter: one-hot grant, priority passes to the other
// requester whenever a grant is taken (adv_i).
module goboard_rr_arb (
    input  logic       vga_clk_in,
    input  logic       arst_i,
    input  logic [1:0] req_i,
    input  logic       adv_i,
    output logic [1:0] gnt_o
);

    logic prio_q, prio_d;

    always_comb begin
        gnt_o = 2'b00;
        if (!prio_q) begin
            if (req_i[0]) begin
                gnt_o = 2'b01;
            end else if (req_i[1]) begin
                gnt_o = 2'b10;
            end
        end else begin
            if (req_i[1]) begin
                gnt_o = 2'b10;
            end else if (req_i[0]) begin
                gnt_o = 2'b01;
            end
        end
    end

    // After serving requester 0 the pointer favours 1, and vice versa.
    always_comb begin
        prio_d = prio_q;
        if (adv_i && (gnt_o != 2'b00)) begin
            prio_d = gnt_o[0];
        end
    end

    always_ff @(posedge vga_clk_in or posedge arst_i) begin
        if (arst_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/goboard_update_sched.sv
// Read-modify-write scheduler for the 19x38 board row memory; all traffic starts
// in vertical blanking. Optional occupancy check: GOBOARD_OCCUPIED_CHECK_EN.
module goboard_update_sched
    import goboard_pkg::*;
(
    input  logic             vga_clk_in,
    input  logic             arst_i,
    input  logic             vblank_i,
    input  logic [1:0]       req_i,
    input  logic [9:0]       x_i,
    input  logic [9:0]       y_i,
    input  logic [3:0]       code_i,
    input  logic             clr_i,
    output logic [1:0]       ack_o,
    output logic [1:0]       err_o,
    output logic             clr_done_o,
    output logic             busy_o,
    output logic [4:0]       mem_addr_o,
    output logic             mem_rd_en_o,
    input  logic [ROW_W-1:0] mem_rdata_i,
    output logic             mem_we_o,
    output logic [ROW_W-1:0] mem_wdata_o
);

    sched_state_e     state_q, state_d;
    logic [1:0]       gnt;
    logic             sel, grant_adv, req_bad;
    logic [4:0]       x_sel, y_sel;
    logic [1:0]       code_sel;
    logic             gnt_idx_q;
    logic [4:0]       x_q, y_q;
    logic [1:0]       code_q;
    logic [ROW_W-1:0] row_q, row_d;
    logic [4:0]       row_cnt_q, row_cnt_d;
    logic             clr_pend_q, clr_pend_d;
    logic             clr_done_q, clr_done_d;
    logic             occ_q, occ_d;
    logic [1:0]       ack_onehot;

    assign sel       = gnt[1];
    assign x_sel     = sel ? x_i[9:5] : x_i[4:0];
    assign y_sel     = sel ? y_i[9:5] : y_i[4:0];
    assign code_sel  = sel ? code_i[3:2] : code_i[1:0];
    assign req_bad   = (x_sel > LAST_ROW) || (y_sel > LAST_ROW) || (code_sel == CELL_RSVD);
    assign grant_adv = (state_q == StIdle) && vblank_i && !clr_pend_q && (req_i != 2'b00);

    assign ack_onehot = gnt_idx_q ? 2'b10 : 2'b01;
    assign clr_done_o = clr_done_q;
    assign busy_o     = (state_q != StIdle) || clr_pend_q;

    goboard_rr_arb u_arb (
        .vga_clk_in (vga_clk_in),
        .arst_i     (arst_i),
        .req_i      (req_i),
        .adv_i      (grant_adv),
        .gnt_o      (gnt)
    );

    always_comb begin
        state_d     = state_q;
        row_cnt_d   = row_cnt_q;
        clr_pend_d  = clr_pend_q | clr_i;
        clr_done_d  = 1'b0;
        row_d       = row_q;
        occ_d       = occ_q;
        ack_o       = 2'b00;
        err_o       = 2'b00;
        mem_addr_o  = 5'd0;
        mem_rd_en_o = 1'b0;
        mem_we_o    = 1'b0;
        mem_wdata_o = '0;

        unique case (state_q)
            StIdle: begin
                if (vblank_i) begin
                    if (clr_pend_q) begin
                        state_d   = StClear;
                        row_cnt_d = 5'd0;
                    end else if (req_i != 2'b00) begin
                        state_d = req_bad ? StReject : StRead;
                    end
                end
            end
            StRead: begin
                mem_addr_o  = y_q;
                mem_rd_en_o = 1'b1;
                state_d     = StModify;
            end
            StModify: begin
                row_d   = set_cell(mem_rdata_i, x_q, code_q);
`ifdef GOBOARD_OCCUPIED_CHECK_EN
                occ_d   = (code_q != CELL_EMPTY) &&
                          (2'(mem_rdata_i >> {x_q, 1'b0}) != CELL_EMPTY);
`else
                occ_d   = 1'b0;
`endif
                state_d = StWrite;
            end
            StWrite: begin
                mem_addr_o = y_q;
                ack_o      = ack_onehot;
                if (occ_q) begin
                    err_o = ack_onehot;
                end else begin
                    mem_we_o    = 1'b1;
                    mem_wdata_o = row_q;
                end
                state_d = StIdle;
            end
            StReject: begin
                ack_o   = ack_onehot;
                err_o   = ack_onehot;
                state_d = StIdle;
            end
            StClear: begin
                mem_addr_o = row_cnt_q;
                // Losing blanking pauses the sweep; the row counter simply holds.
                if (vblank_i) begin
                    mem_we_o = 1'b1;
                    if (row_cnt_q == LAST_ROW) begin
                        state_d    = StIdle;
                        clr_pend_d = 1'b0;
                        clr_done_d = 1'b1;
                    end else begin
                        row_cnt_d = row_cnt_q + 5'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge vga_clk_in or posedge arst_i) begin
        if (arst_i) begin
            state_q    <= StIdle;
            gnt_idx_q  <= 1'b0;
            x_q        <= 5'd0;
            y_q        <= 5'd0;
            code_q     <= CELL_EMPTY;
            row_q      <= '0;
            row_cnt_q  <= 5'd0;
            clr_pend_q <= 1'b0;
            clr_done_q <= 1'b0;
            occ_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_cnt_q  <= row_cnt_d;
            clr_pend_q <= clr_pend_d;
            clr_done_q <= clr_done_d;
            occ_q      <= occ_d;
            if (grant_adv) begin
                gnt_idx_q <= sel;
                x_q       <= x_sel;
                y_q       <= y_sel;
                code_q    <= code_sel;
            end
        end
    end

endmodule
